// File: rtl/gmii_tx_arbiter_if.sv
// gmii_tx_arbiter_if
//   Bundles the two-port frame source handshake and the GMII transmit
//   pins of gmii_tx_arbiter.
//   s_valid[1:0]  per-port byte valid (bit n = port n)
//   s_data[15:0]  per-port byte, port n on [8n+7:8n]
//   s_last[1:0]   per-port last byte of frame (no FCS)
//   s_ready[1:0]  per-port byte accept
//   TX_EN/TXD/TX_ER  GMII transmit pins
//   tx_busy       arbiter not idle
//   tx_done[1:0]  per-port frame-sent pulse
//   tx_err[1:0]   per-port frame-aborted pulse
interface gmii_tx_arbiter_if;
    logic [1:0]  s_valid;
    logic [15:0] s_data;
    logic [1:0]  s_last;
    logic [1:0]  s_ready;
    logic        TX_EN;
    logic [7:0]  TXD;
    logic        TX_ER;
    logic        tx_busy;
    logic [1:0]  tx_done;
    logic [1:0]  tx_err;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, TX_EN, TXD, TX_ER, tx_busy, tx_done, tx_err
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, TX_EN, TXD, TX_ER, tx_busy, tx_done, tx_err
    );
endinterface

// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter
//   Shares one GMII transmit path between two frame sources (port 0 = ARP
//   responder, port 1 = UDP/IP transmitter). Round-robin grant at frame
//   boundaries; adds preamble/SFD, zero padding up to MIN_LEN, CRC-32 FCS
//   and the inter-frame gap. Underrun or oversize frames are aborted with
//   one TX_ER cycle and the rest of the source frame is drained.
//   GTX_CLK  125 MHz transmit clock
//   rst      synchronous active-high reset
//   bus      gmii_tx_arbiter_if slave: source handshake in, GMII pins and
//            status pulses out
module gmii_tx_arbiter #(
    parameter logic [7:0] PRE        = 8'h55,
    parameter logic [7:0] SFD        = 8'hD5,
    parameter int         PRE_LEN    = 7,
    parameter int         MIN_LEN    = 60,
    parameter int         MAX_LEN    = 1514,
    parameter int         IFG_CYCLES = 12
) (
    input logic               GTX_CLK,
    input logic               rst,
    gmii_tx_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, DATA, PAD, FCS, DRAIN, IFG
    } state_t;

    state_t      state;
    logic        grant;
    logic        last_grant;
    logic [31:0] crc;
    logic [10:0] byte_cnt;
    logic [7:0]  step_cnt;
    logic        abort_pend;
    logic        tx_en_r;
    logic [7:0]  txd_r;
    logic        tx_er_r;
    logic [1:0]  tx_done_r;
    logic [1:0]  tx_err_r;

    logic        g_next;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic [10:0] byte_cnt_nx;
    logic        data_abort;
    logic [31:0] fcs_word;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int unsigned i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        g_next      = (&bus.s_valid) ? ~last_grant : bus.s_valid[1];
        in_valid    = bus.s_valid[grant];
        in_data     = grant ? bus.s_data[15:8] : bus.s_data[7:0];
        in_last     = bus.s_last[grant];
        byte_cnt_nx = byte_cnt + 11'd1;
        // Underrun, or the MAX_LEN-th byte arriving without s_last.
        data_abort  = !in_valid || (!in_last && int'(byte_cnt_nx) == MAX_LEN);
        fcs_word    = ~crc;
    end

    always_ff @(posedge GTX_CLK) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            crc        <= '1;
            byte_cnt   <= '0;
            step_cnt   <= '0;
            abort_pend <= 1'b0;
            tx_en_r    <= 1'b0;
            txd_r      <= '0;
            tx_er_r    <= 1'b0;
            tx_done_r  <= '0;
            tx_err_r   <= '0;
        end else begin
            tx_done_r <= '0;
            tx_err_r  <= '0;
            case (state)
                IDLE: begin
                    if (|bus.s_valid) begin
                        grant      <= g_next;
                        last_grant <= g_next;
                        state      <= PREAMBLE;
                        tx_en_r    <= 1'b1;
                        tx_er_r    <= 1'b0;
                        txd_r      <= PRE;
                        step_cnt   <= 8'd1;
                        crc        <= '1;
                        byte_cnt   <= '0;
                    end
                end
                PREAMBLE: begin
                    if (int'(step_cnt) == PRE_LEN) begin
                        txd_r <= SFD;
                        state <= DATA;
                    end else begin
                        txd_r    <= PRE;
                        step_cnt <= step_cnt + 8'd1;
                    end
                end
                DATA: begin
                    if (data_abort) begin
                        // TX_EN stays high for the TX_ER cycle; DRAIN drops it
                        // and raises tx_err one cycle later.
                        txd_r      <= '0;
                        tx_er_r    <= 1'b1;
                        abort_pend <= 1'b1;
                        byte_cnt   <= '0;
                        state      <= DRAIN;
                    end else begin
                        txd_r    <= in_data;
                        crc      <= crc_byte(crc, in_data);
                        byte_cnt <= byte_cnt_nx;
                        if (in_last) begin
                            step_cnt <= '0;
                            state    <= (int'(byte_cnt_nx) < MIN_LEN) ? PAD : FCS;
                        end
                    end
                end
                PAD: begin
                    txd_r    <= '0;
                    crc      <= crc_byte(crc, 8'h00);
                    byte_cnt <= byte_cnt_nx;
                    if (int'(byte_cnt_nx) >= MIN_LEN) begin
                        step_cnt <= '0;
                        state    <= FCS;
                    end
                end
                FCS: begin
                    if (step_cnt == 8'd4) begin
                        tx_en_r          <= 1'b0;
                        txd_r            <= '0;
                        tx_done_r[grant] <= 1'b1;
                        step_cnt         <= '0;
                        state            <= IFG;
                    end else begin
                        txd_r    <= fcs_word[{step_cnt[1:0], 3'b000} +: 8];
                        step_cnt <= step_cnt + 8'd1;
                    end
                end
                DRAIN: begin
                    tx_en_r <= 1'b0;
                    tx_er_r <= 1'b0;
                    txd_r   <= '0;
                    if (abort_pend) begin
                        tx_err_r[grant] <= 1'b1;
                        abort_pend      <= 1'b0;
                    end
                    if (in_valid) begin
                        byte_cnt <= byte_cnt_nx;
                        if (in_last || int'(byte_cnt_nx) == MAX_LEN) begin
                            step_cnt <= '0;
                            state    <= IFG;
                        end
                    end
                end
                IFG: begin
                    // The IDLE cycle before the next grant is the last gap cycle.
                    if (int'(step_cnt) + 2 >= IFG_CYCLES)
                        state <= IDLE;
                    else
                        step_cnt <= step_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_ready = (state == DATA || state == DRAIN) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign bus.tx_busy = (state != IDLE);
    assign bus.TX_EN   = tx_en_r;
    assign bus.TXD     = txd_r;
    assign bus.TX_ER   = tx_er_r;
    assign bus.tx_done = tx_done_r;
    assign bus.tx_err  = tx_err_r;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// tb_gmii_tx_arbiter
//   Scoreboard bench for gmii_tx_arbiter. Instance dut uses default
//   parameters; dut_b uses MIN_LEN=0 for the CRC check-value frame.
module tb_gmii_tx_arbiter;

    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    always #4 clk = ~clk;
    logic rst;

    gmii_tx_arbiter_if a_if();
    gmii_tx_arbiter_if b_if();

    logic       v0, v1, l0, l1, vb, lb;
    logic [7:0] d0, d1, db;

    assign a_if.s_valid = {v1, v0};
    assign a_if.s_data  = {d1, d0};
    assign a_if.s_last  = {l1, l0};
    assign b_if.s_valid = {vb, 1'b0};
    assign b_if.s_data  = {db, 8'h00};
    assign b_if.s_last  = {lb, 1'b0};

    gmii_tx_arbiter dut (.GTX_CLK(clk), .rst(rst), .bus(a_if));
    gmii_tx_arbiter #(.MIN_LEN(0)) dut_b (.GTX_CLK(clk), .rst(rst), .bus(b_if));

    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] exp_q[$];
    int exp_len_q[$];
    int exp_done_q[$];
    int exp_err_q[$];
    logic [7:0] rxb[$];
    bit mon_en = 0, gap_chk = 0, seen = 0, drv_kill = 0, prev_en = 0;
    int gap = 0, run_len = 0, ready_viol = 0, acc0 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Non-reflected shift register fed LSB first; the reflected CRC is its bit reverse.
    function automatic logic [31:0] ref_fcs(input byte_q_t b);
        logic [31:0] c = '1;
        logic [31:0] r;
        logic fb;
        foreach (b[k]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[31] ^ b[k][i];
                c = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        for (int i = 0; i < 32; i++) r[i] = c[31-i];
        return ~r;
    endfunction

    function automatic byte_q_t ramp(input int n, input logic [7:0] base);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(base + 8'(i));
        return q;
    endfunction

    task automatic push_frame(input int p, input byte_q_t pl, input int minl);
        byte_q_t f;
        logic [31:0] fcs;
        f = pl;
        while (f.size() < minl) f.push_back(8'h00);
        fcs = ref_fcs(f);
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (f[k]) exp_q.push_back(f[k]);
        for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
        exp_len_q.push_back(8 + f.size() + 4);
        exp_done_q.push_back(p);
    endtask

    task automatic drive(input int p, input logic v, input logic [7:0] d, input logic l);
        if (p == 0) begin v0 = v; d0 = d; l0 = l; end
        else begin v1 = v; d1 = d; l1 = l; end
    endtask

    task automatic send_byte(input int p, input logic [7:0] b, input logic last);
        int n = 0;
        drive(p, 1'b1, b, last);
        forever begin
            @(negedge clk);
            if (drv_kill) return;
            if (a_if.s_ready[p]) break;
            n++;
            if (n > 2000) begin
                check("ready_timeout", n, 0);
                drv_kill = 1;
                return;
            end
        end
        @(posedge clk);
        #1;
        if (p == 0) acc0++;
    endtask

    task automatic send_frame(input int p, input byte_q_t pl, input bit last_at_end);
        foreach (pl[k]) begin
            if (drv_kill) break;
            send_byte(p, pl[k], last_at_end && (k == pl.size() - 1));
        end
        drive(p, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((exp_len_q.size() != 0 || exp_done_q.size() != 0 || exp_err_q.size() != 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) check("idle_timeout", exp_len_q.size() + exp_done_q.size() + exp_err_q.size(), 0);
        repeat (14) @(negedge clk);
    endtask

    // Output monitor for dut
    always @(negedge clk) begin
        if (a_if.s_ready == 2'b11) ready_viol++;
        if (mon_en) begin
            if (a_if.TX_EN && !prev_en) begin
                if (gap_chk && seen) check("ifg_gap", gap, 12);
                seen = 1;
                gap = 0;
                run_len = 0;
            end
            if (a_if.TX_EN) begin
                run_len++;
                if (a_if.TX_ER) check("er_txd", a_if.TXD, 0);
                else if (exp_q.size() == 0) check("txd_unexp", a_if.TX_EN, 0);
                else check("txd", a_if.TXD, exp_q.pop_front());
            end else begin
                gap++;
                if (a_if.TX_ER) check("er_idle", a_if.TX_ER, 0);
                if (prev_en) begin
                    if (exp_len_q.size() == 0) check("width_unexp", run_len, 0);
                    else check("en_width", run_len, exp_len_q.pop_front());
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (a_if.tx_done[p]) begin
                    if (exp_done_q.size() == 0) check("done_unexp", a_if.tx_done, 0);
                    else check("done_port", p, exp_done_q.pop_front());
                end
                if (a_if.tx_err[p]) begin
                    if (exp_err_q.size() == 0) check("err_unexp", a_if.tx_err, 0);
                    else check("err_port", p, exp_err_q.pop_front());
                end
            end
        end
        prev_en = a_if.TX_EN;
    end

    always @(negedge clk) if (b_if.TX_EN) rxb.push_back(b_if.TXD);

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        byte_q_t pa, pb, pc, pd;
        int n;
        rst = 1'b1;
        v0 = 0; v1 = 0; d0 = 0; d1 = 0; l0 = 0; l1 = 0;
        vb = 0; db = 0; lb = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_en", a_if.TX_EN, 0);
        check("rst_txd", a_if.TXD, 0);
        check("rst_tx_er", a_if.TX_ER, 0);
        check("rst_ready", a_if.s_ready, 0);
        check("rst_busy", a_if.tx_busy, 0);
        check("rst_done", a_if.tx_done, 0);
        check("rst_err", a_if.tx_err, 0);
        rst = 1'b0;
        mon_en = 1;

        // CRC check value on dut_b: "123456789" from port 1
        for (int k = 0; k < 9; k++) begin
            vb = 1'b1;
            db = 8'h31 + 8'(k);
            lb = (k == 8);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!b_if.s_ready[1] && n < 100);
            @(posedge clk);
            #1;
        end
        vb = 1'b0;
        lb = 1'b0;
        n = 0;
        while (!b_if.tx_done[1] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("crc_done_seen", b_if.tx_done, 2'b10);
        @(negedge clk);
        check("crc_len", rxb.size(), 21);
        if (rxb.size() == 21) begin
            check("crc_sfd", rxb[7], 8'hD5);
            check("crc_b0", rxb[17], 8'h26);
            check("crc_b1", rxb[18], 8'h39);
            check("crc_b2", rxb[19], 8'hF4);
            check("crc_b3", rxb[20], 8'hCB);
        end

        // Single 64-byte frame from port 0
        pa = ramp(64, 8'h00);
        push_frame(0, pa, 60);
        send_frame(0, pa, 1'b1);
        wait_idle(500);

        // Short frame padded to 60 bytes
        pa = ramp(10, 8'hA0);
        push_frame(0, pa, 60);
        send_frame(0, pa, 1'b1);
        wait_idle(500);

        // Underrun on port 1 after 20 bytes
        pa = ramp(20, 8'h40);
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (pa[k]) exp_q.push_back(pa[k]);
        exp_len_q.push_back(29);
        exp_err_q.push_back(1);
        send_frame(1, pa, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        pb = ramp(40, 8'h80);
        send_frame(1, pb, 1'b1);
        wait_idle(500);
        check("under_no_busy", a_if.tx_busy, 0);

        // Reset in the middle of a port 0 frame
        mon_en = 0;
        acc0 = 0;
        pa = ramp(60, 8'h00);
        fork
            send_frame(0, pa, 1'b1);
            begin
                n = 0;
                while (acc0 < 30 && n < 500) begin
                    @(negedge clk);
                    n++;
                end
                check("rst_mid_reach30", (acc0 >= 30), 1);
                rst = 1'b1;
                drv_kill = 1;
                @(posedge clk);
                #1;
                check("rstm_tx_en", a_if.TX_EN, 0);
                check("rstm_tx_er", a_if.TX_ER, 0);
                check("rstm_ready", a_if.s_ready, 0);
                check("rstm_busy", a_if.tx_busy, 0);
                check("rstm_err", a_if.tx_err, 0);
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
            end
        join
        exp_q.delete();
        exp_len_q.delete();
        exp_done_q.delete();
        exp_err_q.delete();
        drv_kill = 0;
        seen = 0;
        gap_chk = 1;
        mon_en = 1;

        // Round-robin with both ports continuously valid; port 0 first after reset
        pa = ramp(60, 8'h10);
        pb = ramp(60, 8'h50);
        pc = ramp(60, 8'h90);
        pd = ramp(60, 8'hC0);
        push_frame(0, pa, 60);
        push_frame(1, pc, 60);
        push_frame(0, pb, 60);
        push_frame(1, pd, 60);
        fork
            begin
                send_frame(0, pa, 1'b1);
                send_frame(0, pb, 1'b1);
            end
            begin
                send_frame(1, pc, 1'b1);
                send_frame(1, pd, 1'b1);
            end
        join
        wait_idle(2000);

        check("ready_exclusive", ready_viol, 0);
        check("exp_bytes_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
